// File: rtl/round_key_sequencer.sv
// AES-128 round-key source: streams the 11 round keys in forward (encrypt) or reverse (decrypt)
// order over a valid/ready interface, using one shared 4-byte S-box bank.
module round_key_sequencer (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Start,
    input  logic [127:0] i_Key,
    input  logic         i_fEncrypt,
    output logic         o_Idle,
    output logic         o_Valid,
    input  logic         i_Ready,
    output logic [127:0] o_Key,
    output logic [3:0]   o_RoundNum,
    output logic         o_Last
);

    typedef enum logic [1:0] {StIdle, StPrecomp, StEmit} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         mode_q, mode_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, b;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, x);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, x);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, x);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, x);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, x);
        b    = gf_mul(x127, x127);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  inv_w1, inv_w2, inv_w3;
    logic [31:0]  sub_src, rot, sub, t;
    logic [31:0]  f0, f1, f2, f3;
    logic [3:0]   rcon_idx;
    logic         use_inv;
    logic         last;
    logic [127:0] fwd_key, inv_key;

    assign {w0, w1, w2, w3} = key_q;
    assign inv_w3 = w2 ^ w3;
    assign inv_w2 = w1 ^ w2;
    assign inv_w1 = w0 ^ w1;

    // The S-box bank sees w3 for a forward step and the recovered w3' for an inverse step.
    assign use_inv  = (state_q == StEmit) && !mode_q;
    assign sub_src  = use_inv ? inv_w3 : w3;
    assign rot      = {sub_src[23:0], sub_src[31:24]};
    assign sub      = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign rcon_idx = (state_q == StEmit && mode_q) ? round_q + 4'd1 : round_q;
    assign t        = sub ^ {rcon(rcon_idx), 24'h0};

    assign f0 = w0 ^ t;
    assign f1 = f0 ^ w1;
    assign f2 = f1 ^ w2;
    assign f3 = f2 ^ w3;
    assign fwd_key = {f0, f1, f2, f3};
    assign inv_key = {w0 ^ t, inv_w1, inv_w2, inv_w3};

    assign last = (state_q == StEmit) && (mode_q ? (round_q == 4'd10) : (round_q == 4'd0));

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (i_Start) begin
                    key_d  = i_Key;
                    mode_d = i_fEncrypt;
                    if (i_fEncrypt) begin
                        state_d = StEmit;
                        round_d = 4'd0;
                    end else begin
                        state_d = StPrecomp;
                        round_d = 4'd1;
                    end
                end
            end
            StPrecomp: begin
                // round_q doubles as the step counter; it is left at 10 for the first emit.
                key_d = fwd_key;
                if (round_q == 4'd10) begin
                    state_d = StEmit;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            StEmit: begin
                if (i_Ready) begin
                    if (last) begin
                        state_d = StIdle;
                    end else if (mode_q) begin
                        key_d   = fwd_key;
                        round_d = round_q + 4'd1;
                    end else begin
                        key_d   = inv_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= '0;
            mode_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    assign o_Idle     = (state_q == StIdle);
    assign o_Valid    = (state_q == StEmit);
    assign o_Key      = key_q;
    assign o_RoundNum = round_q;
    assign o_Last     = last;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Self-checking bench for round_key_sequencer: FIPS-197 key schedule table, scenario table,
// scoreboard of expected keys, plus hand-written reset sequences.
module tb_round_key_sequencer;

    logic         clk;
    logic         i_Rst, i_Start, i_fEncrypt, i_Ready;
    logic [127:0] i_Key;
    logic         o_Idle, o_Valid, o_Last;
    logic [127:0] o_Key;
    logic [3:0]   o_RoundNum;

    round_key_sequencer dut (
        .i_Clk      (clk),
        .i_Rst      (i_Rst),
        .i_Start    (i_Start),
        .i_Key      (i_Key),
        .i_fEncrypt (i_fEncrypt),
        .o_Idle     (o_Idle),
        .o_Valid    (o_Valid),
        .i_Ready    (i_Ready),
        .o_Key      (o_Key),
        .o_RoundNum (o_RoundNum),
        .o_Last     (o_Last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        logic         last;
    } exp_t;

    typedef struct {
        bit         fenc;
        logic [3:0] stall_round;
        int         stall_len;
        bit         glitch;
        int         exp_lat;
    } scen_t;

    localparam logic [127:0] Key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] rk [0:10];
    scen_t        scen [0:4];
    exp_t         sb [$];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare presented key against the scoreboard head on the falling edge; pop on handshake.
    task automatic tick();
        @(negedge clk);
        if (o_Valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 128'(o_Valid), 128'd0);
            end else begin
                check("key", o_Key, sb[0].key);
                check("round", 128'(o_RoundNum), 128'(sb[0].round));
                check("last", 128'(o_Last), 128'(sb[0].last));
                if (i_Ready) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input bit fenc);
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.round = fenc ? 4'(i) : 4'(10 - i);
            e.key   = rk[e.round];
            e.last  = fenc ? (i == 10) : (i == 10);
            sb.push_back(e);
        end
    endtask

    task automatic start(input bit fenc);
        check("idle_before_start", 128'(o_Idle), 128'd1);
        i_Start    = 1'b1;
        i_Key      = Key;
        i_fEncrypt = fenc;
        push_stream(fenc);
        tick();
        // Post-capture input changes must not matter.
        i_Start    = 1'b0;
        i_Key      = ~Key;
        i_fEncrypt = ~fenc;
    endtask

    task automatic run_stream(input scen_t s);
        int cycles;
        int stall_cnt;
        bit stall_done;
        cycles     = 1;
        stall_cnt  = 0;
        stall_done = 0;
        start(s.fenc);
        while (sb.size() != 0 && cycles < 80) begin
            if (cycles < s.exp_lat) begin
                check("precomp_valid", 128'(o_Valid), 128'd0);
                check("precomp_idle", 128'(o_Idle), 128'd0);
                check("precomp_last", 128'(o_Last), 128'd0);
            end else if (cycles == s.exp_lat) begin
                check("first_valid", 128'(o_Valid), 128'd1);
            end
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) i_Ready = 1'b1;
            end else if (!stall_done && o_Valid && o_RoundNum == s.stall_round) begin
                stall_done = 1;
                stall_cnt  = s.stall_len;
                i_Ready    = 1'b0;
            end
            if (s.glitch && cycles == 5) begin
                i_Start    = 1'b1;
                i_Key      = 128'h00112233445566778899aabbccddeeff;
                i_fEncrypt = ~s.fenc;
            end else begin
                i_Start = 1'b0;
            end
            tick();
            cycles++;
        end
        i_Ready = 1'b1;
        i_Start = 1'b0;
        check("stream_done", 128'(sb.size()), 128'd0);
        check("end_valid", 128'(o_Valid), 128'd0);
        check("end_idle", 128'(o_Idle), 128'd1);
        sb.delete();
    endtask

    task automatic check_reset_state();
        check("rst_valid", 128'(o_Valid), 128'd0);
        check("rst_key", o_Key, 128'd0);
        check("rst_round", 128'(o_RoundNum), 128'd0);
        check("rst_idle", 128'(o_Idle), 128'd1);
        check("rst_last", 128'(o_Last), 128'd0);
    endtask

    initial begin
        rk[0]  = Key;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        //         fenc  stall_round  len  glitch  latency
        scen[0] = '{1'b1, 4'hf,       0,   1'b0,   1};
        scen[1] = '{1'b0, 4'hf,       0,   1'b0,   11};
        scen[2] = '{1'b1, 4'd4,       3,   1'b0,   1};
        scen[3] = '{1'b0, 4'hf,       0,   1'b1,   11};
        scen[4] = '{1'b1, 4'hf,       0,   1'b1,   1};

        i_Rst      = 1'b1;
        i_Start    = 1'b0;
        i_Key      = '0;
        i_fEncrypt = 1'b1;
        i_Ready    = 1'b1;
        tick();
        tick();
        check_reset_state();
        i_Rst = 1'b0;
        tick();

        // Scenarios run back-to-back: each start lands in the cycle after the last handshake.
        for (int i = 0; i < 5; i++) run_stream(scen[i]);

        // Reset during decrypt precompute.
        start(1'b0);
        for (int i = 0; i < 5; i++) tick();
        i_Rst = 1'b1;
        tick();
        check_reset_state();
        i_Rst = 1'b0;
        sb.delete();
        run_stream(scen[0]);

        // Reset while encrypt round 6 is presented.
        start(1'b1);
        for (int i = 0; i < 20 && !(o_Valid && o_RoundNum == 4'd6); i++) tick();
        check("reached_round6", 128'(o_RoundNum), 128'd6);
        i_Rst = 1'b1;
        tick();
        check_reset_state();
        i_Rst = 1'b0;
        sb.delete();
        run_stream(scen[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
